// File: rtl/vga_plot_sink.sv
// Plot-interface responder: 160x120x3 framebuffer written by a drawing block,
// scanned out as 640x480@60 VGA with each stored pixel shown as a 4x4 block.
module vga_plot_sink #(
    parameter int         H_VIS     = 640,
    parameter int         H_FP      = 16,
    parameter int         H_SYNC    = 96,
    parameter int         H_BP      = 48,
    parameter int         V_VIS     = 480,
    parameter int         V_FP      = 10,
    parameter int         V_SYNC    = 2,
    parameter int         V_BP      = 33,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    input  logic       clear,
    output logic       busy,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK,
    output logic       VGA_SYNC,
    output logic       VGA_CLK
);

    localparam int          H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int          V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0]  H_VIS_C = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_C = 10'(V_VIS);
    localparam logic [9:0]  HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_VIS + V_FP + V_SYNC);
    localparam int          FB_SIZE = 160 * 120;
    localparam logic [14:0] FB_LAST = 15'(FB_SIZE - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_q, state_d;
    logic [14:0] clr_addr_q, clr_addr_d;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic        plot_ok;
    logic [14:0] plot_addr;

    logic        pix_en_q;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        vis;
    logic        hs_n;
    logic        vs_n;
    logic [14:0] rd_addr;

    logic [2:0]  fb_mem [FB_SIZE];
    logic [2:0]  rd_p1_q;
    logic        hs_p1_q, vs_p1_q, blank_p1_q;
    logic        hs_p2_q, vs_p2_q, blank_p2_q;
    logic [2:0]  rgb_p2_q;

    assign plot_ok   = plot && (x < 8'd160) && (y < 7'd120);
    assign plot_addr = {8'd0, y} * 15'd160 + {7'd0, x};

    // Clear/plot control FSM
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear) state_d = CLEAR;
            CLEAR:   if (clr_addr_q == FB_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A plot in the same IDLE cycle as clear is still written; the clear follows.
    always_comb begin
        busy       = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = plot_addr;
        wr_data    = colour;
        clr_addr_d = '0;
        case (state_q)
            IDLE: begin
                wr_en = plot_ok;
            end
            CLEAR: begin
                busy       = 1'b1;
                wr_en      = 1'b1;
                wr_addr    = clr_addr_q;
                wr_data    = BG_COLOUR;
                clr_addr_d = clr_addr_q + 15'd1;
            end
            default: ;
        endcase
    end

    // Scan counters, advanced on every other CLOCK_50 cycle
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pix_en_q <= 1'b0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
        end else begin
            pix_en_q <= ~pix_en_q;
            if (pix_en_q) begin
                h_cnt_q <= h_cnt_d;
                v_cnt_q <= v_cnt_d;
            end
        end
    end

    assign vis     = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    assign hs_n    = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    assign vs_n    = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    // Blanked positions read address 0 so the index never leaves the array.
    assign rd_addr = vis ? ({7'd0, v_cnt_q[9:2]} * 15'd160 + {7'd0, h_cnt_q[9:2]}) : 15'd0;

    // Stage p1: framebuffer read; non-blocking update gives read-before-write
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) fb_mem[wr_addr] <= wr_data;
        if (pix_en_q) rd_p1_q <= fb_mem[rd_addr];
    end

    // Stage p1 -> p2: syncs follow the read data so both reach the pins together
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            hs_p1_q    <= 1'b1;
            vs_p1_q    <= 1'b1;
            blank_p1_q <= 1'b0;
            hs_p2_q    <= 1'b1;
            vs_p2_q    <= 1'b1;
            blank_p2_q <= 1'b0;
            rgb_p2_q   <= 3'b000;
        end else if (pix_en_q) begin
            hs_p1_q    <= hs_n;
            vs_p1_q    <= vs_n;
            blank_p1_q <= vis;
            hs_p2_q    <= hs_p1_q;
            vs_p2_q    <= vs_p1_q;
            blank_p2_q <= blank_p1_q;
            rgb_p2_q   <= blank_p1_q ? rd_p1_q : 3'b000;
        end
    end

    assign VGA_R     = {10{rgb_p2_q[2]}};
    assign VGA_G     = {10{rgb_p2_q[1]}};
    assign VGA_B     = {10{rgb_p2_q[0]}};
    assign VGA_HS    = hs_p2_q;
    assign VGA_VS    = vs_p2_q;
    assign VGA_BLANK = blank_p2_q;
    assign VGA_SYNC  = 1'b0;
    assign VGA_CLK   = pix_en_q;

endmodule
